// File: rtl/fpu_operand_feeder_if.sv
// Handshake and operand/result bus of the FPU operand feeder.
// slave  : the feeder itself.
// master : the environment (upstream source, adder and downstream sink).
interface fpu_operand_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] Asem;
  logic [15:0] Bsem;
  logic [15:0] Rsem;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [7:0]  op_count;

  modport slave (
    input  in_valid, in_a, in_b, Rsem, out_ready,
    output in_ready, Asem, Bsem, out_valid, out_result, op_count
  );

  modport master (
    output in_valid, in_a, in_b, Rsem, out_ready,
    input  in_ready, Asem, Bsem, out_valid, out_result, op_count
  );
endinterface

// File: rtl/fpu_operand_feeder.sv
// FPU operand feeder: buffers half-precision operand pairs in a 4-entry FIFO,
// presents one pair at a time to an external combinational adder, and
// registers the sum for a valid/ready downstream.
//
// Compile-time option:
//   FPU_NAN_BYPASS_EN - when defined, a NaN on either registered operand
//                       forces the result to the canonical quiet NaN 16'h7E00
//                       instead of the adder output. Timing is unchanged.
//
// state  | meaning
// IDLE   | no pair in flight; pops the FIFO head as soon as one is present
// SETTLE | operands registered, adder output settling; captured next edge
// HOLD   | result valid, waiting for out_ready
module fpu_operand_feeder (
  input  logic                        clk,
  input  logic                        rst_n,
  fpu_operand_feeder_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] fifo_mem [0:3];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  fifo_cnt;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  logic        capture;
  logic        release_res;

  logic [15:0] asem_q;
  logic [15:0] bsem_q;
  logic [15:0] result_q;
  logic        out_valid_q;
  logic [7:0]  op_count_q;
  logic [15:0] result_d;

  assign fifo_full  = (fifo_cnt == 3'd4);
  assign fifo_empty = (fifo_cnt == 3'd0);
  // Full is evaluated on the registered count, so a pop in the same cycle
  // cannot open a slot for a push until the following cycle.
  assign push       = bus.in_valid && !fifo_full;

  assign bus.in_ready   = !fifo_full;
  assign bus.Asem       = asem_q;
  assign bus.Bsem       = bsem_q;
  assign bus.out_result = result_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.op_count   = op_count_q;

`ifdef FPU_NAN_BYPASS_EN
  function automatic logic is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction

  assign result_d = (is_nan(asem_q) || is_nan(bsem_q)) ? 16'h7E00 : bus.Rsem;
`else
  assign result_d = bus.Rsem;
`endif

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.in_a, bus.in_b};
    end
  end

  // FIFO pointers and occupancy; 2-bit pointers wrap naturally 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and control strobes.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          release_res = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand registers feeding the adder; loaded only on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asem_q <= 16'h0000;
      bsem_q <= 16'h0000;
    end else if (pop) begin
      asem_q <= fifo_mem[rd_ptr][31:16];
      bsem_q <= fifo_mem[rd_ptr][15:0];
    end
  end

  // Result register, valid flag and consumed-result counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= 16'h0000;
      out_valid_q <= 1'b0;
      op_count_q  <= 8'd0;
    end else begin
      if (capture) begin
        result_q    <= result_d;
        out_valid_q <= 1'b1;
      end else if (release_res) begin
        out_valid_q <= 1'b0;
      end
      if (release_res) begin
        op_count_q <= op_count_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_operand_feeder.sv
// Self-checking bench for fpu_operand_feeder. The adder attached to Asem/Bsem
// is a real-arithmetic half-precision model; a queue of accepted pairs with
// their expected sums is checked against the DUT outputs every cycle.
`timescale 1ns/1ps
module tb_fpu_operand_feeder;

  logic clk;
  logic rst_n;

  fpu_operand_feeder_if bus ();

  fpu_operand_feeder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
  } ent_t;

  ent_t        exp_q [$];
  int          hs_times [$];
  int          hs_total  = 0;
  int          acc_total = 0;
  int          cyc       = 0;
  logic [7:0]  exp_cnt   = 8'd0;

  logic [15:0] seq_a [0:511];
  logic [15:0] seq_b [0:511];

  // ---------------- half-precision arithmetic model ----------------
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic logic is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real mag;
    if (h[14:10] == 5'd0) mag = real'(h[9:0]) * pow2(-24);
    else                  mag = (1024.0 + real'(h[9:0])) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    logic        s;
    real         a;
    real         sc;
    real         fr;
    int          e;
    int          ip;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    if (a >= 65520.0) return {s, 15'h7C00};
    if (a < pow2(-14)) begin
      e  = 0;
      sc = a / pow2(-24);
    end else begin
      e = 30;
      while (e > 1 && a < pow2(e - 15)) e--;
      sc = a / pow2(e - 25);
    end
    ip = $rtoi(sc);
    fr = sc - real'(ip);
    if (fr > 0.5 || (fr == 0.5 && (ip % 2) == 1)) ip++;
    if (e == 0) return {s, 15'(ip)};
    if (ip >= 2048) begin
      ip = 1024;
      e++;
    end
    if (e > 30) return {s, 15'h7C00};
    return {s, 5'(e), 10'(ip - 1024)};
  endfunction

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a)) return a | 16'h0200;
    if (is_nan(b)) return b | 16'h0200;
    return r2h(h2r(a) + h2r(b));
  endfunction

  function automatic logic [15:0] expected_result(input logic [15:0] a, input logic [15:0] b);
`ifdef FPU_NAN_BYPASS_EN
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
`endif
    return fp16_add(a, b);
  endfunction

  assign bus.Rsem = fp16_add(bus.Asem, bus.Bsem);

  function automatic logic [15:0] gen_a(input int i);
    return {1'b0, 5'(13 + i % 4), 10'(i * 37)};
  endfunction

  function automatic logic [15:0] gen_b(input int i);
    return {1'((i % 3) == 0), 5'(12 + i % 5), 10'(i * 91 + 5)};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   16'(bus.in_ready),  16'd1);
    chk({tag, "_out_valid"},  16'(bus.out_valid), 16'd0);
    chk({tag, "_asem"},       bus.Asem,           16'h0000);
    chk({tag, "_bsem"},       bus.Bsem,           16'h0000);
    chk({tag, "_out_result"}, bus.out_result,     16'h0000);
    chk({tag, "_op_count"},   16'(bus.op_count),  16'd0);
  endtask

  // Per-cycle comparison against the queue model, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 8'd0;
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stale_result: got out_valid=1 result %h expected no result", bus.out_result);
        end else begin
          chk("cmp_out_result", bus.out_result, exp_q[0].r);
          chk("cmp_asem",       bus.Asem,       exp_q[0].a);
          chk("cmp_bsem",       bus.Bsem,       exp_q[0].b);
        end
      end
      chk("cmp_op_count", 16'(bus.op_count), 16'(exp_cnt));
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 8'd1;
        hs_total++;
        hs_times.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{a: bus.in_a, b: bus.in_b, r: expected_result(bus.in_a, bus.in_b)});
        acc_total++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_seq(input int off, input int n, input int budget, output int acc);
    int   ncyc;
    logic ok;
    acc  = 0;
    ncyc = 0;
    while (acc < n && ncyc < budget) begin
      bus.in_valid = 1'b1;
      bus.in_a     = seq_a[off + acc];
      bus.in_b     = seq_b[off + acc];
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) acc++;
      ncyc++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_hs(input string name, input int target, input int budget);
    int n = 0;
    while (hs_total < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 16'(hs_total), 16'(target));
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 16'(bus.out_valid), 16'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int acc;
    logic [15:0] nan_exp;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'h0000;
    bus.in_b      = 16'h0000;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst_init");

    // Latency: release reset and offer 1.0 + 1.0 for the very next edge.
    @(posedge clk);
    #3;
    rst_n         = 1'b1;
    bus.in_a      = 16'h3C00;
    bus.in_b      = 16'h3C00;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("lat_e0_valid", 16'(bus.out_valid), 16'd0);
    chk("lat_e0_asem",  bus.Asem,           16'h0000);
    @(posedge clk);
    #1;
    chk("lat_e1_asem",  bus.Asem,           16'h3C00);
    chk("lat_e1_bsem",  bus.Bsem,           16'h3C00);
    chk("lat_e1_valid", 16'(bus.out_valid), 16'd0);
    @(posedge clk);
    #1;
    chk("lat_e2_valid",  16'(bus.out_valid), 16'd1);
    chk("lat_e2_result", bus.out_result,     16'h4000);
    @(posedge clk);
    #1;
    chk("lat_e3_valid", 16'(bus.out_valid), 16'd0);
    chk("lat_e3_count", 16'(bus.op_count),  16'd1);

    // Capacity: out_ready low, six distinct pairs offered back to back.
    bus.out_ready = 1'b0;
    seq_a[0] = 16'h3C00;
    seq_b[0] = 16'h4000;
    for (int i = 1; i < 6; i++) begin
      seq_a[i] = gen_a(i);
      seq_b[i] = gen_b(i);
    end
    base = hs_total;
    push_seq(0, 6, 12, acc);
    chk("cap_accepted", 16'(acc),           16'd5);
    chk("cap_in_ready", 16'(bus.in_ready),  16'd0);
    chk("cap_valid",    16'(bus.out_valid), 16'd1);
    chk("cap_result",   bus.out_result,     16'h4200);
    repeat (3) @(posedge clk);
    #1;
    chk("cap_hold_result", bus.out_result, 16'h4200);
    chk("cap_hold_asem",   bus.Asem,       16'h3C00);
    chk("cap_hold_bsem",   bus.Bsem,       16'h4000);
    bus.out_ready = 1'b1;
    wait_hs("cap_drain", base + 5, 40);
    repeat (2) @(posedge clk);
    #1;
    chk("cap_idle_valid", 16'(bus.out_valid), 16'd0);
    chk("cap_idle_ready", 16'(bus.in_ready),  16'd1);

    // Ordering, throughput and pointer wrap over 8 pairs.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seq_a[i] = gen_a(i + 20);
      seq_b[i] = gen_b(i + 20);
    end
    base = hs_total;
    push_seq(0, 4, 10, acc);
    chk("tput_first4", 16'(acc), 16'd4);
    bus.out_ready = 1'b1;
    push_seq(4, 4, 30, acc);
    chk("tput_last4", 16'(acc), 16'd4);
    wait_hs("tput_drain", base + 8, 60);
    if (hs_total >= base + 8) begin
      for (int i = 0; i < 7; i++) begin
        chk("tput_gap", 16'(hs_times[base + i + 1] - hs_times[base + i]), 16'd2);
      end
    end

    // NaN operand followed by an ordinary pair.
`ifdef FPU_NAN_BYPASS_EN
    nan_exp = 16'h7E00;
`else
    nan_exp = 16'h7E01;
`endif
    seq_a[0] = 16'h7E01;
    seq_b[0] = 16'h3C00;
    seq_a[1] = 16'h4000;
    seq_b[1] = 16'h4000;
    base = hs_total;
    push_seq(0, 2, 10, acc);
    wait_valid("nan_valid", 20);
    chk("nan_result", bus.out_result, nan_exp);
    wait_hs("nan_drain", base + 2, 20);
    chk("nan_follow_result", bus.out_result, 16'h4400);

    // Reset while holding a result with three pairs queued.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seq_a[i] = gen_a(i + 40);
      seq_b[i] = gen_b(i + 40);
    end
    push_seq(0, 4, 10, acc);
    chk("rstmid_accepted", 16'(acc),           16'd4);
    chk("rstmid_holding",  16'(bus.out_valid), 16'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(posedge clk);
    #2;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rstmid_no_valid", 16'(bus.out_valid), 16'd0);
    chk("rstmid_count",    16'(bus.op_count),  16'd0);
    chk("rstmid_asem",     bus.Asem,           16'h0000);

    // 256 handshakes wrap op_count back to zero.
    for (int i = 0; i < 256; i++) begin
      seq_a[i] = gen_a(i + 100);
      seq_b[i] = gen_b(i + 100);
    end
    base = hs_total;
    push_seq(0, 256, 1200, acc);
    chk("wrap_accepted", 16'(acc), 16'd256);
    wait_hs("wrap_drain", base + 256, 200);
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_count", 16'(bus.op_count), 16'd0);
    chk("final_queue_empty", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
